pixel_readback: RTL and testbench

- Reads processed RGB pixel words back out of data memory after a program run, through a dedicated synchronous read port.
- The pipeline's memory stage is the writer to that memory; this block is the reader on the same interface.
- Serialises each pixel word into R, G, B bytes on a valid/ready byte stream toward the host link (UART transmitter).
- Sits beside the data memory at the processor top level and is triggered by a start pulse once the program has finished.

---
 rtl/pixel_readback_pkg.sv | 26 ++
 rtl/pixel_byte_serializer.sv | 55 +++++
 rtl/pixel_readback.sv | 91 +++++++++
 tb/tb_pixel_readback.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readback_pkg.sv
// Shared types and byte-lane constants for the pixel readback path.
package pixel_readback_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    FINISH
  } state_t;

  localparam int R_MSB           = 23;
  localparam int G_MSB           = 15;
  localparam int B_MSB           = 7;
  localparam int BYTES_PER_PIXEL = 3;

  // Selects the colour byte for a given lane index (0=R, 1=G, 2=B).
  function automatic logic [7:0] lane_byte(input logic [23:0] pix, input logic [1:0] idx);
    case (idx)
      2'd0:    lane_byte = pix[R_MSB -: 8];
      2'd1:    lane_byte = pix[G_MSB -: 8];
      default: lane_byte = pix[B_MSB -: 8];
    endcase
  endfunction

endpackage

// File: rtl/pixel_byte_serializer.sv
// Holds one pixel word and streams its R, G, B bytes over valid/ready.
module pixel_byte_serializer
  import pixel_readback_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              last_accepted
);

  logic [23:0] pix_q;
  logic [1:0]  byte_idx;
  logic        accept;

  // Colour data lives in the low 24 bits; anything above is padding.
  generate
    if (DATA_W > 24) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^word[DATA_W-1:24];
    end
  endgenerate

  assign accept        = tx_valid & tx_ready;
  assign last_accepted = accept && (byte_idx == 2'(BYTES_PER_PIXEL - 1));

  always_ff @(posedge clk) begin
    if (load) pix_q <= word[23:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (load) begin
      byte_idx <= '0;
      tx_valid <= 1'b1;
      tx_data  <= word[R_MSB -: 8];
    end else if (accept) begin
      if (last_accepted) begin
        tx_valid <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        tx_data  <= lane_byte(pix_q, byte_idx + 2'd1);
      end
    end
  end

endmodule

// File: rtl/pixel_readback.sv
// Reads the pixel buffer out of data memory port B and streams it as RGB bytes.
module pixel_readback
  import pixel_readback_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_PIXELS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic              load;
  logic              last_accepted;

  // Read data arrives during WAIT, so the serializer captures it at that edge.
  assign load = (state == WAIT);

  pixel_byte_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .word         (mem_rd_data),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .last_accepted(last_accepted)
  );

  // mem_rd_en and done are set on entry so each is high for exactly one state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      pix_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr  <= BASE;
            pix_cnt   <= '0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        READ:   state <= WAIT;
        WAIT:   state <= SEND;
        SEND: begin
          if (last_accepted) begin
            if (pix_cnt == LAST_PIX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              pix_cnt   <= pix_cnt + ADDR_W'(1);
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readback.sv
// Scoreboard bench: expected addresses/bytes queued at start, checked by a monitor.
module tb_pixel_readback;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int BASE_ADDR  = 14;
  localparam int NUM_PIXELS = 3;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  int n_tests    = 0;
  int n_fail     = 0;
  int done_cnt   = 0;
  int ready_mode = 0;
  int byte_cnt   = 0;

  logic [7:0] exp_bytes[$];
  int         exp_addrs[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  pixel_readback #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .NUM_PIXELS(NUM_PIXELS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tx_ready: 0 = always ready, 1 = random, 2 = four stall cycles per byte
  initial begin
    int st;
    st = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          st = (st == 4) ? 0 : st + 1;
          tx_ready = (st == 4);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      if (mem_rd_en) begin
        if (exp_addrs.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL addr_extra: read at %0h with no read expected", mem_addr);
        end else begin
          check("mem_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
        end
      end
      if (tx_valid && tx_ready) begin
        byte_cnt++;
        if (exp_bytes.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL byte_extra: got %0h with no byte expected", tx_data);
        end else begin
          check("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("done_addrs_left", 32'(exp_addrs.size()), 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      if (i % 2 == 0) mem[i][31:24] = 8'hFF;
    end
  endtask

  // Reference: pixel p sits at (BASE+p) mod memory size; bytes R,G,B from bits 23..0.
  task automatic push_expected();
    for (int p = 0; p < NUM_PIXELS; p++) begin
      int a;
      logic [31:0] w;
      a = (BASE_ADDR + p) % MEM_WORDS;
      w = mem[a];
      exp_addrs.push_back(a);
      exp_bytes.push_back(8'((w / 65536) % 256));
      exp_bytes.push_back(8'((w / 256) % 256));
      exp_bytes.push_back(8'(w % 256));
    end
  endtask

  task automatic run_xfer(input int mode, input bit timed, input bit extra_start);
    int done_k;
    int done_before;
    int bytes_before;
    ready_mode = mode;
    fill_mem();
    push_expected();
    done_before  = done_cnt;
    bytes_before = byte_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 3000 && done_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_c1", 32'(busy), 32'd1);
        check("rd_en_c1", 32'(mem_rd_en), 32'd1);
      end
      if (timed && k == 2) check("tx_valid_c2", 32'(tx_valid), 32'd0);
      if (timed && k == 3) check("tx_valid_c3", 32'(tx_valid), 32'd1);
      if (extra_start && k == 9) start = 1'b1;
      if (extra_start && k == 10) start = 1'b0;
      if (done) done_k = k;
    end
    start = 1'b0;
    if (done_k == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: no done within 3000 cycles");
    end else begin
      check("busy_at_done", 32'(busy), 32'd0);
      if (timed) check("done_cycle", 32'(done_k), 32'(5 * NUM_PIXELS + 1));
      // A start raised during FINISH must not launch a new transfer.
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("finish_start_busy", 32'(busy), 32'd0);
      check("finish_start_rd", 32'(mem_rd_en), 32'd0);
    end
    repeat (3) @(negedge clk);
    check("done_count", 32'(done_cnt - done_before), 32'd1);
    check("byte_count", 32'(byte_cnt - bytes_before), 32'(3 * NUM_PIXELS));
  endtask

  task automatic abort_xfer();
    int done_before;
    logic [31:0] w;
    ready_mode = 0;
    fill_mem();
    push_expected();
    w = mem[BASE_ADDR];
    done_before = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_G", 32'(tx_data), 32'((w / 256) % 256));
    #2 rst = 1'b0;
    #1;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_rd_en", 32'(mem_rd_en), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_bytes.delete();
    exp_addrs.delete();
    repeat (4) @(negedge clk);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - done_before), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(0, 1'b1, 1'b0);
    run_xfer(2, 1'b0, 1'b0);
    run_xfer(1, 1'b0, 1'b1);
    abort_xfer();
    run_xfer(0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) run_xfer(1 + (r % 2), 1'b0, r[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
